bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_if.sv | 40 ++++
 rtl/bus_arbiter_rr_select.sv | 32 +++
 rtl/bus_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types, defaults and helpers for the bus arbiter
// Contents: FSM state encoding, default address/data width, byte-enable width helper.
package bus_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int be_width(input int xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester and bus-side signal bundle for the bus arbiter
// Requester side: i_req, i_wr_en, i_addr, i_wr_data, i_byte_en (packed per port), o_ready, o_err, o_rd_data.
// Bus side:       o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en, i_ack, i_rd_data.
// master: the arbiter's view; slave: the environment (requesters plus bus target).
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int XLEN   = XLEN_DEFAULT
);
    localparam int BEW = be_width(XLEN);

    logic [NPORTS-1:0]      i_req;
    logic [NPORTS-1:0]      i_wr_en;
    logic [NPORTS*XLEN-1:0] i_addr;
    logic [NPORTS*XLEN-1:0] i_wr_data;
    logic [NPORTS*BEW-1:0]  i_byte_en;
    logic [NPORTS-1:0]      o_ready;
    logic [NPORTS-1:0]      o_err;
    logic [XLEN-1:0]        o_rd_data;

    logic                   i_ack;
    logic [XLEN-1:0]        i_rd_data;
    logic                   o_bus_en;
    logic                   o_wr_en;
    logic [XLEN-1:0]        o_wr_data;
    logic [XLEN-1:0]        o_addr;
    logic [BEW-1:0]         o_byte_en;

    modport master (
        input  i_req, i_wr_en, i_addr, i_wr_data, i_byte_en, i_ack, i_rd_data,
        output o_ready, o_err, o_rd_data, o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en
    );

    modport slave (
        output i_req, i_wr_en, i_addr, i_wr_data, i_byte_en, i_ack, i_rd_data,
        input  o_ready, o_err, o_rd_data, o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en
    );

endinterface

// File: rtl/bus_arbiter_rr_select.sv
// rtl/bus_arbiter_rr_select.sv - combinational rotating-priority request selector
// Ports: i_req (request vector), i_last (index granted last), o_gnt (one-hot grant), o_idx (grant index).
// The search starts at i_last+1 and wraps, so the last winner has lowest priority.
module rr_select #(
    parameter int NPORTS = 2,
    parameter int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [IW-1:0]     i_last,
    output logic [NPORTS-1:0] o_gnt,
    output logic [IW-1:0]     o_idx
);

    logic found;
    int   p;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        p     = 0;
        for (int i = 1; i <= NPORTS; i++) begin
            p = (int'(i_last) + i) % NPORTS;
            if (!found && i_req[p]) begin
                found    = 1'b1;
                o_gnt[p] = 1'b1;
                o_idx    = IW'(p);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter from NPORTS requesters onto one bus target
// Ports: i_clk, i_rst (async, active-high), bif (bus_arbiter_if.master: requester and bus sides).
// Flow: IDLE grants and latches the winner's command, BUSY drives it until i_ack or
// timeout, DONE pulses o_ready (and o_err on timeout) for one cycle.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int TIMEOUT = 255,
    parameter int XLEN    = XLEN_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    bus_arbiter_if.master bif
);

    localparam int BEW = be_width(XLEN);
    localparam int IW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter stops at TIMEOUT-1: the cycle it holds that value is the TIMEOUT-th bus cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] LAST_RST = IW'(NPORTS - 1);

    state_e            state_q;
    logic [IW-1:0]     last_q;
    logic [IW-1:0]     grant_q;
    logic [NPORTS-1:0] grant_oh_q;
    logic [CW-1:0]     cnt_q;
    logic              bus_en_q;
    logic              wr_en_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [BEW-1:0]    be_q;
    logic [NPORTS-1:0] ready_q;
    logic [NPORTS-1:0] err_q;
    logic [XLEN-1:0]   rdata_q;

    logic [NPORTS-1:0] sel_oh_d;
    logic [IW-1:0]     sel_idx_d;
    logic              timeout_d;

    rr_select #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_rr_select (
        .i_req  (bif.i_req),
        .i_last (last_q),
        .o_gnt  (sel_oh_d),
        .o_idx  (sel_idx_d)
    );

    assign timeout_d = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            last_q     <= LAST_RST;
            grant_q    <= '0;
            grant_oh_q <= '0;
            cnt_q      <= '0;
            bus_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            ready_q    <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            ready_q <= '0;
            err_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|bif.i_req) begin
                        grant_q    <= sel_idx_d;
                        grant_oh_q <= sel_oh_d;
                        bus_en_q   <= 1'b1;
                        wr_en_q    <= bif.i_wr_en[sel_idx_d];
                        addr_q     <= bif.i_addr[int'(sel_idx_d)*XLEN +: XLEN];
                        wdata_q    <= bif.i_wr_data[int'(sel_idx_d)*XLEN +: XLEN];
                        be_q       <= bif.i_byte_en[int'(sel_idx_d)*BEW +: BEW];
                        cnt_q      <= '0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // i_ack is tested first so it wins over a coincident timeout.
                    if (bif.i_ack) begin
                        rdata_q  <= bif.i_rd_data;
                        bus_en_q <= 1'b0;
                        ready_q  <= grant_oh_q;
                        last_q   <= grant_q;
                        state_q  <= ST_DONE;
                    end else if (timeout_d) begin
                        rdata_q  <= '0;
                        bus_en_q <= 1'b0;
                        ready_q  <= grant_oh_q;
                        err_q    <= grant_oh_q;
                        last_q   <= grant_q;
                        state_q  <= ST_DONE;
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    // One dead cycle lets the requester retire i_req before rearbitration.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bif.o_bus_en  = bus_en_q;
    assign bif.o_wr_en   = wr_en_q;
    assign bif.o_addr    = addr_q;
    assign bif.o_wr_data = wdata_q;
    assign bif.o_byte_en = be_q;
    assign bif.o_ready   = ready_q;
    assign bif.o_err     = err_q;
    assign bif.o_rd_data = rdata_q;

endmodule
